// File: rtl/vec_cla_pkg.sv
// Shared types and helpers for the vector carry-lookahead adder.
//   sew_e         : element width selector (8/16/32/64 bits)
//   op_e          : add or subtract (a-b)
//   elem_msb_byte : per-byte boundary mask, true on the most significant byte
//                   of each element
package vec_cla_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Elements are 2^sew bytes long, so byte_idx closes an element when
  // (byte_idx + 1) is a multiple of that byte count.
  function automatic logic elem_msb_byte(sew_e sew, int unsigned byte_idx);
    int unsigned bytes_per_elem;
    bytes_per_elem = 32'd1 << sew;
    return ((byte_idx + 32'd1) % bytes_per_elem) == 32'd0;
  endfunction

endpackage

// File: rtl/vec_cla_add_pipe_cla_group.sv
// One carry-lookahead group of BLOCK bits.
//   a, b    : group operand slices (b already inverted for subtract)
//   g, p    : bitwise generate / propagate
//   grp_g   : group generate (carry out of the group with carry-in 0)
//   grp_p   : group propagate (carry-in passes straight through)
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] g,
  output logic [BLOCK-1:0] p,
  output logic             grp_g,
  output logic             grp_p
);

  function automatic logic [1:0] reduce_gp(logic [BLOCK-1:0] gi, logic [BLOCK-1:0] pi);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      gg = gi[i] | (pi[i] & gg);
      pp = pp & pi[i];
    end
    return {gg, pp};
  endfunction

  assign g = a & b;
  assign p = a ^ b;
  assign {grp_g, grp_p} = reduce_gp(g, p);

endmodule

// File: rtl/vec_cla_add_pipe.sv
// Two-stage pipelined SIMD adder/subtractor built from carry-lookahead groups.
// Carries are cut at every element boundary selected by sew_i.
// Optional feature: define VEC_CLA_SAT_EN to enable unsigned saturation
// under sat_i; otherwise sat_i is ignored and results wrap.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   in_valid_i / in_ready_o    : operand beat handshake
//   a_i, b_i                   : WIDTH-bit operands
//   sew_i, op_i, sat_i         : element width, add/sub, saturate request
//   out_valid_o / out_ready_i  : result handshake
//   sum_o                      : per-element result
//   cout_o                     : per-byte carry flags, set only on element MSB bytes
module vec_cla_add_pipe
  import vec_cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BLOCK = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [1:0]         sew_i,
  input  logic               op_i,
  input  logic               sat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   sum_o,
  output logic [WIDTH/8-1:0] cout_o
);

  localparam int NG = WIDTH / BLOCK;
  localparam int NB = WIDTH / 8;

  logic advance;
  assign advance    = !out_valid_o || out_ready_i;
  assign in_ready_o = advance;

  // Subtract is a + ~b + 1; the +1 enters as the element carry-in in stage 2.
  logic [WIDTH-1:0] b_eff_p0;
  logic [WIDTH-1:0] g_p0, p_p0;
  logic [NG-1:0]    gg_p0, gp_p0;

  assign b_eff_p0 = op_i ? ~b_i : b_i;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a     (a_i[gi*BLOCK +: BLOCK]),
      .b     (b_eff_p0[gi*BLOCK +: BLOCK]),
      .g     (g_p0[gi*BLOCK +: BLOCK]),
      .p     (p_p0[gi*BLOCK +: BLOCK]),
      .grp_g (gg_p0[gi]),
      .grp_p (gp_p0[gi])
    );
  end

  // ---- stage 1: bitwise and group G/P registers ----
  logic             vld_p1;
  logic [WIDTH-1:0] g_p1, p_p1;
  logic [NG-1:0]    gg_p1, gp_p1;
  sew_e             sew_p1;
  op_e              op_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i)        vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= in_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (advance && in_valid_i) begin
      g_p1   <= g_p0;
      p_p1   <= p_p0;
      gg_p1  <= gg_p0;
      gp_p1  <= gp_p0;
      sew_p1 <= sew_e'(sew_i);
      op_p1  <= op_e'(op_i);
    end
  end

`ifdef VEC_CLA_SAT_EN
  logic sat_p1;
  always_ff @(posedge clk_i) begin
    if (advance && in_valid_i) sat_p1 <= sat_i;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_i;
`endif

  // Group carries ripple through G'/P'; a group that opens an element
  // takes the element carry-in instead of the previous group's carry-out.
  function automatic logic [WIDTH-1:0] carry_vec(
    logic [WIDTH-1:0] g, logic [WIDTH-1:0] p,
    logic [NG-1:0] gg, logic [NG-1:0] gp,
    logic [NB-1:0] msb, logic cin
  );
    logic [WIDTH-1:0] c;
    logic             grp_co;
    int               start;
    c      = '0;
    grp_co = 1'b0;
    for (int j = 0; j < NG; j++) begin
      start = j * BLOCK;
      if (j == 0 || ((start % 8) == 0 && msb[(start - 1) / 8])) c[start] = cin;
      else                                                    c[start] = grp_co;
      for (int t = 1; t < BLOCK; t++)
        c[start+t] = g[start+t-1] | (p[start+t-1] & c[start+t-1]);
      grp_co = gg[j] | (gp[j] & c[start]);
    end
    return c;
  endfunction

`ifdef VEC_CLA_SAT_EN
  // Walk bytes from the top so each byte sees its own element's carry-out.
  function automatic logic [WIDTH-1:0] saturate(
    logic [WIDTH-1:0] sum, logic [NB-1:0] msb, logic [NB-1:0] co_byte,
    op_e op, logic sat
  );
    logic [WIDTH-1:0] r;
    logic             ec;
    r  = sum;
    ec = 1'b0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (msb[k]) ec = co_byte[k];
      if (sat) begin
        if (op == OP_ADD && ec)       r[8*k +: 8] = 8'hFF;
        else if (op == OP_SUB && !ec) r[8*k +: 8] = 8'h00;
      end
    end
    return r;
  endfunction
`endif

  logic [NB-1:0]    msb;
  logic [WIDTH-1:0] carry;
  logic [NG-1:0]    co_grp;
  logic [NB-1:0]    co_byte;
  logic [WIDTH-1:0] sum_next;
  logic [NB-1:0]    cout_next;

  always_comb begin
    msb = '0;
    for (int k = 0; k < NB; k++)
      msb[k] = (k == NB - 1) || elem_msb_byte(sew_p1, unsigned'(k));
  end

  assign carry = carry_vec(g_p1, p_p1, gg_p1, gp_p1, msb, op_p1 == OP_SUB);

  always_comb begin
    co_grp = '0;
    for (int j = 0; j < NG; j++)
      co_grp[j] = gg_p1[j] | (gp_p1[j] & carry[j*BLOCK]);
  end

  // BLOCK divides 8, so every byte top bit closes a group.
  always_comb begin
    co_byte = '0;
    for (int k = 0; k < NB; k++)
      co_byte[k] = co_grp[(8*k + 7) / BLOCK];
  end

  assign cout_next = msb & co_byte;

`ifdef VEC_CLA_SAT_EN
  assign sum_next = saturate(p_p1 ^ carry, msb, co_byte, op_p1, sat_p1);
`else
  assign sum_next = p_p1 ^ carry;
`endif

  // ---- stage 2: result registers ----
  logic             vld_p2;
  logic [WIDTH-1:0] sum_p2;
  logic [NB-1:0]    cout_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2  <= sum_next;
        cout_p2 <= cout_next;
      end
    end
  end

  assign out_valid_o = vld_p2;
  assign sum_o       = sum_p2;
  assign cout_o      = cout_p2;

endmodule

// File: tb/tb_vec_cla_add_pipe.sv
module tb_vec_cla_add_pipe;

`ifdef VEC_CLA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a, b;
  logic [1:0]  sew;
  logic        op, sat;

  logic        in_ready, out_valid;
  logic [63:0] sum;
  logic [7:0]  cout;
  logic        in_ready_b2, out_valid_b2;
  logic [63:0] sum_b2;
  logic [7:0]  cout_b2;
  logic        in_ready_b8, out_valid_b8;
  logic [63:0] sum_b8;
  logic [7:0]  cout_b8;

  int n_checks = 0;
  int n_errors = 0;

  vec_cla_add_pipe #(.WIDTH(64), .BLOCK(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .sew_i(sew), .op_i(op), .sat_i(sat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum), .cout_o(cout)
  );

  vec_cla_add_pipe #(.WIDTH(64), .BLOCK(2)) dut_b2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b2),
    .a_i(a), .b_i(b), .sew_i(sew), .op_i(op), .sat_i(sat),
    .out_valid_o(out_valid_b2), .out_ready_i(out_ready), .sum_o(sum_b2), .cout_o(cout_b2)
  );

  vec_cla_add_pipe #(.WIDTH(64), .BLOCK(8)) dut_b8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b8),
    .a_i(a), .b_i(b), .sew_i(sew), .op_i(op), .sat_i(sat),
    .out_valid_o(out_valid_b8), .out_ready_i(out_ready), .sum_o(sum_b8), .cout_o(cout_b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Element-wise arithmetic reference.
  function automatic void model(input logic [63:0] ma, input logic [63:0] mb,
                                input logic [1:0] msew, input logic mop, input logic msat,
                                output logic [63:0] s, output logic [7:0] co);
    int          esz;
    logic [64:0] m, ae, be, r, res;
    logic        c;
    esz = 8 << msew;
    m   = (65'd1 << esz) - 65'd1;
    s   = '0;
    co  = '0;
    for (int e = 0; e < 64 / esz; e++) begin
      ae = ({1'b0, ma} >> (e * esz)) & m;
      be = ({1'b0, mb} >> (e * esz)) & m;
      if (mop) r = ae + (~be & m) + 65'd1;
      else     r = ae + be;
      c   = r[esz];
      res = r & m;
      if (SAT_EN && msat) begin
        if (!mop && c)     res = m;
        else if (mop && !c) res = '0;
      end
      s = s | (res[63:0] << (e * esz));
      co[((e + 1) * esz) / 8 - 1] = c;
    end
  endfunction

  task automatic drive(input logic [63:0] da, input logic [63:0] db,
                       input logic [1:0] dsew, input logic dop, input logic dsat);
    in_valid = 1'b1;
    a = da; b = db; sew = dsew; op = dop; sat = dsat;
  endtask

  task automatic run_one(input string tag, input logic [63:0] da, input logic [63:0] db,
                         input logic [1:0] dsew, input logic dop, input logic dsat,
                         input logic [63:0] exp_sum, input logic [7:0] exp_cout);
    drive(da, db, dsew, dop, dsat);
    step();
    in_valid = 1'b0;
    check_val({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_sum"}, sum, exp_sum);
    check_val({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    step();
  endtask

  logic [63:0] q_sum[$];
  logic [7:0]  q_cout[$];
  logic [63:0] ms, es;
  logic [7:0]  mc, ec;
  logic [63:0] stream_sum[4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sew = 2'd0; op = 1'b0; sat = 1'b0;
    step();
    step();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_sum", sum, 64'd0);
    check_val("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    step();
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors.
    run_one("sew64_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 1'b0, 1'b0, 64'd0, 8'h80);
    run_one("sew8_add", 64'h01FF_01FF_01FF_01FF, 64'h0101_0101_0101_0101, 2'd0, 1'b0, 1'b0,
            64'h0200_0200_0200_0200, 8'h55);
    run_one("sew16_sub", {4{16'h0001}}, {4{16'h0002}}, 2'd1, 1'b1, 1'b0, {4{16'hFFFF}}, 8'h00);
    run_one("sew16_sub_sat", {4{16'h0001}}, {4{16'h0002}}, 2'd1, 1'b1, 1'b1,
            SAT_EN ? 64'd0 : {4{16'hFFFF}}, 8'h00);
    run_one("sew8_add_sat", {8{8'hF0}}, {8{8'h20}}, 2'd0, 1'b0, 1'b1,
            SAT_EN ? {8{8'hFF}} : {8{8'h10}}, 8'hFF);
    run_one("sew32_sub_cut", 64'h0000_0005_0000_0000, 64'h0000_0003_0000_0001, 2'd2, 1'b1, 1'b0,
            64'h0000_0002_FFFF_FFFF, 8'h80);
    run_one("sew32_add_cut", 64'h0000_0000_FFFF_FFFF, 64'd1, 2'd2, 1'b0, 1'b0, 64'd0, 8'h08);
    run_one("sew16_add", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 2'd1, 1'b0, 1'b0,
            64'd0, 8'h22);
    run_one("sew64_sub_eq", 64'd5, 64'd5, 2'd3, 1'b1, 1'b0, 64'd0, 8'h80);

    // Four-beat stream with a three-cycle output stall.
    stream_sum[0] = 64'h01; stream_sum[1] = 64'h12; stream_sum[2] = 64'h23; stream_sum[3] = 64'h34;
    drive(64'h00, 64'd1, 2'd3, 1'b0, 1'b0);
    step();
    drive(64'h10, 64'd2, 2'd3, 1'b0, 1'b0);
    step();
    check_val("strm_b0_valid", 64'(out_valid), 64'd1);
    check_val("strm_b0_sum", sum, stream_sum[0]);
    drive(64'h20, 64'd3, 2'd3, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    check_val("strm_stall_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("strm_hold_valid", 64'(out_valid), 64'd1);
      check_val("strm_hold_sum", sum, stream_sum[0]);
      check_val("strm_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("strm_release_ready", 64'(in_ready), 64'd1);
    step();
    check_val("strm_b1_valid", 64'(out_valid), 64'd1);
    check_val("strm_b1_sum", sum, stream_sum[1]);
    drive(64'h30, 64'd4, 2'd3, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check_val("strm_b2_valid", 64'(out_valid), 64'd1);
    check_val("strm_b2_sum", sum, stream_sum[2]);
    step();
    check_val("strm_b3_valid", 64'(out_valid), 64'd1);
    check_val("strm_b3_sum", sum, stream_sum[3]);
    step();
    check_val("strm_done", 64'(out_valid), 64'd0);

    // Reset with a beat in flight.
    drive(64'd7, 64'd8, 2'd3, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("midrst_valid0", 64'(out_valid), 64'd0);
    rst = 1'b0;
    step();
    check_val("midrst_valid1", 64'(out_valid), 64'd0);
    step();
    check_val("midrst_valid2", 64'(out_valid), 64'd0);
    check_val("midrst_ready", 64'(in_ready), 64'd1);
    run_one("post_rst", 64'd7, 64'd8, 2'd3, 1'b0, 1'b0, 64'd15, 8'h00);

    // Random sweep with random bubbles and back-pressure, three group sizes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      if (cyc % 3 == 0) b = ~a;
      if (cyc % 5 == 0) b = a;
      if (cyc % 7 == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
      sew       = 2'($urandom_range(0, 3));
      op        = 1'($urandom_range(0, 1));
      sat       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        model(a, b, sew, op, sat, ms, mc);
        q_sum.push_back(ms);
        q_cout.push_back(mc);
      end
      if (out_valid && out_ready) begin
        if (q_sum.size() == 0) begin
          check_val("rnd_spurious", 64'd1, 64'd0);
        end else begin
          es = q_sum.pop_front();
          ec = q_cout.pop_front();
          check_val("rnd_sum_b4", sum, es);
          check_val("rnd_cout_b4", 64'(cout), 64'(ec));
          check_val("rnd_sum_b2", sum_b2, es);
          check_val("rnd_cout_b2", 64'(cout_b2), 64'(ec));
          check_val("rnd_sum_b8", sum_b8, es);
          check_val("rnd_cout_b8", 64'(cout_b8), 64'(ec));
        end
      end
      check_val("rnd_hs_b2", {62'd0, out_valid_b2, in_ready_b2}, {62'd0, out_valid, in_ready});
      check_val("rnd_hs_b8", {62'd0, out_valid_b8, in_ready_b8}, {62'd0, out_valid, in_ready});
      step();
    end

    // Drain with a bounded cycle budget.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q_sum.size() != 0; cyc++) begin
      #1;
      if (out_valid) begin
        es = q_sum.pop_front();
        ec = q_cout.pop_front();
        check_val("drain_sum", sum, es);
        check_val("drain_cout", 64'(cout), 64'(ec));
      end
      step();
    end
    check_val("drain_left", 64'(q_sum.size()), 64'd0);
    step();
    check_val("final_idle", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
